mem_responder: RTL

- Word-addressed data memory that acts as the responder side of the CPU memory interface (memRead / memWrite / addr / data / dataOut).
- Adds a completion handshake (ready) with a parameterised number of wait states, so the multicycle control FSM can be exercised against a slow memory.
- Includes a side-band preload port so benches can load program/data words.
- Reports misaligned and out-of-range accesses on addrErr.

---
 rtl/mem_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed data memory acting as the responder side of
// the CPU memory interface. Each accepted request completes with a one-cycle
// ready pulse after WAIT_STATES idle cycles. Misaligned, out-of-range and
// illegal (read+write) requests complete with addrErr. A side-band preload
// port writes words directly into the array.
module mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic [31:0]              addr,
  input  logic [31:0]              data,
  output logic [31:0]              dataOut,
  output logic                     ready,
  output logic                     addrErr,
  output logic                     busy,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     waitCnt;
  logic           latRead;
  logic           latWrite;
  logic [31:0]    latAddr;
  logic [31:0]    latData;
  logic [31:0]    mem [DEPTH];

  logic [AW-1:0]  latIndex;
  logic           latErr;
  logic           doWrite;

  // An address is only usable when word aligned and every bit above the
  // word index is zero; asking for both read and write is also an error.
  assign latIndex = latAddr[AW+1:2];
  assign latErr   = (latAddr[1:0] != 2'b00)
                 || (latAddr[31:AW+2] != '0)
                 || (latRead && latWrite);
  assign doWrite  = (state == RESP) && latWrite && !latErr;

  // Transaction FSM: accept in IDLE, count wait states, then respond once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      dataOut  <= '0;
      ready    <= 1'b0;
      addrErr  <= 1'b0;
      busy     <= 1'b0;
      latRead  <= 1'b0;
      latWrite <= 1'b0;
      latAddr  <= '0;
      latData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready   <= 1'b0;
          addrErr <= 1'b0;
          if (memRead || memWrite) begin
            latRead  <= memRead;
            latWrite <= memWrite;
            latAddr  <= addr;
            latData  <= data;
            busy     <= 1'b1;
            waitCnt  <= '0;
            state    <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + 4'd1;
          if (waitCnt + 4'd1 == WAIT_LAST) begin
            state <= RESP;
          end
        end
        RESP: begin
          ready   <= 1'b1;
          busy    <= 1'b0;
          waitCnt <= '0;
          state   <= IDLE;
          if (latErr) begin
            addrErr <= 1'b1;
            dataOut <= '0;
          end else if (latRead) begin
            dataOut <= mem[latIndex];
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array writes: preload first so a same-edge transaction write wins.
  always_ff @(posedge clk) begin
    if (reset && load_en) begin
      mem[load_addr] <= load_data;
    end
    if (doWrite) begin
      mem[latIndex] <= latData;
    end
  end

endmodule
